// File: rtl/muldiv_sequencer_if.sv
// Handshake/result bundle between the EX stage and the mult/div sequencer.
// The EX stage drives the master side and the sequencer takes the slave side.
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_start;
  logic [5:0]       i_funct;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_flush;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_funct, i_a, i_b, i_flush,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_funct, i_a, i_b, i_flush,
    output o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MIPS mult/multu/div/divu engine owning HI/LO.
// Shift-add multiply / restoring divide on magnitudes, then a one-cycle sign fix.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  muldiv_sequencer_if.slave   bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               sgn_op;
  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   quo_sh;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot, rem;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opd_q    <= '0;
      acc_q    <= '0;
      araw_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opd_q    <= opd_d;
      acc_q    <= acc_d;
      araw_q   <= araw_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opd_d    = opd_q;
    acc_d    = acc_q;
    araw_d   = araw_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    // funct[0]==0 selects the signed variants (mult 0x18, div 0x1a)
    sgn_op = ~bus.i_funct[0];
    sa     = sgn_op & bus.i_a[WIDTH-1];
    sb     = sgn_op & bus.i_b[WIDTH-1];
    mag_a  = sa ? (~bus.i_a + 1'b1) : bus.i_a;
    mag_b  = sb ? (~bus.i_b + 1'b1) : bus.i_b;

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
    // rem_sh keeps the bit shifted out of the remainder so the trial compare is exact
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    quo_sh   = {acc_q[WIDTH-2:0], 1'b0};
    diff     = {1'b0, rem_sh} - {2'b00, opd_q};
    prod_fix = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
    quot     = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start && !bus.i_flush) begin
          unique case (bus.i_funct)
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              is_div_d = bus.i_funct[1];
              sign_a_d = sa;
              sign_b_d = sb;
              araw_d   = bus.i_a;
              cnt_d    = CW'(WIDTH - 1);
              state_d  = S_CALC;
              if (bus.i_funct[1]) begin
                acc_d = {{WIDTH{1'b0}}, mag_a};
                opd_d = mag_b;
              end else begin
                acc_d = {{WIDTH{1'b0}}, mag_b};
                opd_d = mag_a;
              end
            end
            F_MTHI:  hi_d = bus.i_a;
            F_MTLO:  lo_d = bus.i_a;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (bus.i_flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            if (!diff[WIDTH+1]) acc_d = {diff[WIDTH-1:0], quo_sh | {{(WIDTH-1){1'b0}}, 1'b1}};
            else                acc_d = {rem_sh[WIDTH-1:0], quo_sh};
          end else if (acc_q[0]) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.i_flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (opd_q == '0) begin
            lo_d = '1;
            hi_d = araw_q;
          end else begin
            lo_d = (sign_a_q ^ sign_b_q) ? (~quot + 1'b1) : quot;
            hi_d = sign_a_q ? (~rem + 1'b1) : rem;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;
  assign bus.o_hi   = hi_q;
  assign bus.o_lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed HI/LO, latency, flush and reset cases.
module tb_muldiv_sequencer;

  localparam int unsigned W = 32;

  logic clk;
  logic rst_n;
  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  bit          cmp_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: result of an operation from plain wide arithmetic
  function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    case (f)
      6'h18: res = 64'(sa * sb);
      6'h19: res = {32'h0, a} * {32'h0, b};
      6'h1a, 6'h1b: begin
        if (b == 32'h0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (f == 6'h1a) begin
          q = sa / sb;
          r = sa % sb;
          res = {32'(r), 32'(q)};
        end else begin
          res = {32'(a % b), 32'(a / b)};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  int          m_remain;
  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  logic        m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_remain = 0;
      m_hi = '0; m_lo = '0; r_hi = '0; r_lo = '0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_remain > 0) begin
        if (bus.i_flush) begin
          m_remain = 0;
        end else begin
          m_remain--;
          if (m_remain == 0) begin
            m_hi = r_hi;
            m_lo = r_lo;
            m_done = 1'b1;
          end
        end
      end else if (bus.i_start && !bus.i_flush) begin
        case (bus.i_funct)
          6'h18, 6'h19, 6'h1a, 6'h1b: begin
            {r_hi, r_lo} = ref_result(bus.i_funct, bus.i_a, bus.i_b);
            m_remain = W + 1;
          end
          6'h11: m_hi = bus.i_a;
          6'h13: m_lo = bus.i_a;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("model_busy", 64'(bus.o_busy), 64'(m_remain > 0));
      check("model_done", 64'(bus.o_done), 64'(m_done));
      check("model_hi",   64'(bus.o_hi),   64'(m_hi));
      check("model_lo",   64'(bus.o_lo),   64'(m_lo));
    end
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_funct = f; bus.i_a = a; bus.i_b = b;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit lit,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int lat, busy_n;
    issue(f, a, b);
    lat = 1;
    busy_n = 0;
    while (1) begin
      if (bus.o_busy) busy_n++;
      if (bus.o_done || lat >= 100) break;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd34);
    check({name, "_busy_cycles"}, 64'(busy_n), 64'd33);
    if (lit) begin
      check({name, "_hi"}, 64'(bus.o_hi), 64'(ehi));
      check({name, "_lo"}, 64'(bus.o_lo), 64'(elo));
    end
  endtask

  typedef struct {
    string       name;
    logic [5:0]  f;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[7] = '{
    '{"multu_max",  6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
    '{"mult_neg",   6'h18, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB},
    '{"div_neg",    6'h1a, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
    '{"divu_100_7", 6'h1b, 32'd100,       32'd7,         32'd2,         32'd14},
    '{"divu_by0",   6'h1b, 32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF},
    '{"div_ovf",    6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000},
    '{"div_by0_s",  6'h1a, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 32'hFFFF_FFFF}
  };

  logic [5:0] rfuncts[4] = '{6'h18, 6'h19, 6'h1a, 6'h1b};

  initial begin
    int dones;
    rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_funct = '0; bus.i_a = '0; bus.i_b = '0; bus.i_flush = 1'b0;
    #12;
    check("reset_busy", 64'(bus.o_busy), 64'd0);
    check("reset_done", 64'(bus.o_done), 64'd0);
    check("reset_hi",   64'(bus.o_hi),   64'd0);
    check("reset_lo",   64'(bus.o_lo),   64'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, 1'b1, vecs[i].hi, vecs[i].lo);

    for (int i = 0; i < 4; i++)
      run_op("rand", rfuncts[i], $urandom, (i == 2) ? 32'($urandom_range(1, 1000)) : $urandom,
             1'b0, '0, '0);

    // mthi then mtlo back-to-back
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_funct = 6'h11; bus.i_a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("mthi_busy", 64'(bus.o_busy), 64'd0);
    bus.i_funct = 6'h13; bus.i_a = 32'h5;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    check("mtx_busy", 64'(bus.o_busy), 64'd0);
    check("mthi_hi",  64'(bus.o_hi), 64'hDEAD_BEEF);
    check("mtlo_lo",  64'(bus.o_lo), 64'h5);

    // unknown funct is ignored
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_funct = 6'h20; bus.i_a = 32'h1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    check("illegal_busy", 64'(bus.o_busy), 64'd0);
    check("illegal_hi",   64'(bus.o_hi), 64'hDEAD_BEEF);

    // flush at CALC cycle 10, with a stray start during CALC
    issue(6'h18, 32'd5, 32'd6);
    repeat (8) begin @(posedge clk); #1; end
    bus.i_start = 1'b1; bus.i_funct = 6'h1b; bus.i_a = 32'd1; bus.i_b = 32'd1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    check("flush_busy_before", 64'(bus.o_busy), 64'd1);
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    check("flush_busy_after", 64'(bus.o_busy), 64'd0);
    dones = 0;
    repeat (40) begin
      if (bus.o_done) dones++;
      @(posedge clk); #1;
    end
    check("flush_no_done", 64'(dones), 64'd0);
    check("flush_hi", 64'(bus.o_hi), 64'hDEAD_BEEF);
    check("flush_lo", 64'(bus.o_lo), 64'h5);

    // flush beats start in IDLE
    bus.i_start = 1'b1; bus.i_flush = 1'b1; bus.i_funct = 6'h11; bus.i_a = 32'h1111;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_flush = 1'b0;
    check("flush_start_hi",   64'(bus.o_hi), 64'hDEAD_BEEF);
    check("flush_start_busy", 64'(bus.o_busy), 64'd0);

    // async reset mid-divide
    issue(6'h1b, 32'd100, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    check("pre_reset_busy", 64'(bus.o_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(bus.o_busy), 64'd0);
    check("rst_mid_done", 64'(bus.o_done), 64'd0);
    check("rst_mid_hi",   64'(bus.o_hi),   64'd0);
    check("rst_mid_lo",   64'(bus.o_lo),   64'd0);
    #20;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
